// File: rtl/sdram_arbit_if.sv
// Engine-side bundle of the SDRAM arbiter: per-engine requests, completions,
// command buses, grants and write data.
interface sdram_arbit_if;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end;

  logic        aref_req;
  logic        wr_req;
  logic        rd_req;
  logic        aref_end;
  logic        wr_end;
  logic        rd_end;

  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;

  logic        wr_sdram_en;
  logic [15:0] wr_data;

  logic        aref_en;
  logic        wr_en;
  logic        rd_en;

  // engines side
  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, wr_req, rd_req, aref_end, wr_end, rd_end,
    output aref_cmd, aref_ba, aref_addr, wr_cmd, wr_ba, wr_addr,
    output rd_cmd, rd_ba, rd_addr, wr_sdram_en, wr_data,
    input  aref_en, wr_en, rd_en
  );

  // arbiter side
  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, wr_req, rd_req, aref_end, wr_end, rd_end,
    input  aref_cmd, aref_ba, aref_addr, wr_cmd, wr_ba, wr_addr,
    input  rd_cmd, rd_ba, rd_addr, wr_sdram_en, wr_data,
    output aref_en, wr_en, rd_en
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init owns the bus until init_end, then fixed priority
// refresh > write > read. Only the state is registered; grants and pin mux are combinational.
//
// state | meaning
// IDLE  | init engine owns the pins, waiting for init_end
// ARBIT | nobody owns the pins (NOP), grants issued here
// AREF  | refresh engine owns the pins until aref_end
// WRITE | write engine owns the pins until wr_end
// READ  | read engine owns the pins until rd_end
module sdram_arbit #(
  parameter logic [3:0]  NOP       = 4'b0111,
  parameter logic [1:0]  IDLE_BA   = 2'b11,
  parameter logic [12:0] IDLE_ADDR = 13'h1fff
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  sdram_arbit_if.slave       eng,
  output logic               sdram_cke,
  output logic               sdram_cs_n,
  output logic               sdram_ras_n,
  output logic               sdram_cas_n,
  output logic               sdram_we_n,
  output logic [1:0]         sdram_ba,
  output logic [12:0]        sdram_addr,
  inout  wire  [15:0]        sdram_dq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  cmd_sel;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  if (eng.init_end) state <= ARBIT;
        ARBIT: begin
          if (eng.aref_req)     state <= AREF;
          else if (eng.wr_req)  state <= WRITE;
          else if (eng.rd_req)  state <= READ;
        end
        AREF:  if (eng.aref_end) state <= ARBIT;
        WRITE: if (eng.wr_end)   state <= ARBIT;
        READ:  if (eng.rd_end)   state <= ARBIT;
        default: state <= IDLE;
      endcase
    end
  end

  // priority encoding guarantees at most one grant per cycle
  assign eng.aref_en = (state == ARBIT) & eng.aref_req;
  assign eng.wr_en   = (state == ARBIT) & ~eng.aref_req & eng.wr_req;
  assign eng.rd_en   = (state == ARBIT) & ~eng.aref_req & ~eng.wr_req & eng.rd_req;

  always_comb begin
    cmd_sel    = NOP;
    sdram_ba   = IDLE_BA;
    sdram_addr = IDLE_ADDR;
    case (state)
      IDLE: begin
        cmd_sel    = eng.init_cmd;
        sdram_ba   = eng.init_ba;
        sdram_addr = eng.init_addr;
      end
      AREF: begin
        cmd_sel    = eng.aref_cmd;
        sdram_ba   = eng.aref_ba;
        sdram_addr = eng.aref_addr;
      end
      WRITE: begin
        cmd_sel    = eng.wr_cmd;
        sdram_ba   = eng.wr_ba;
        sdram_addr = eng.wr_addr;
      end
      READ: begin
        cmd_sel    = eng.rd_cmd;
        sdram_ba   = eng.rd_ba;
        sdram_addr = eng.rd_addr;
      end
      default: begin
        cmd_sel    = NOP;
        sdram_ba   = IDLE_BA;
        sdram_addr = IDLE_ADDR;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_cke = 1'b1;
  assign sdram_dq  = eng.wr_sdram_en ? eng.wr_data : 16'hzzzz;

endmodule
